// File: rtl/morse_digit_tx.sv
// Morse transmitter for one decimal digit taken from a seven-segment pattern or a BCD value.
// Five timed elements are keyed MSB first, then a silent inter-character gap.
module morse_digit_tx #(
  parameter int UNIT_CYCLES    = 4,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sel,
  input  logic [7:0] in_seg,
  input  logic [3:0] in_bcd,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic [4:0] code_out,
  output logic       done,
  output logic       err
);

  localparam int DOT_LEN  = UNIT_CYCLES;
  localparam int DASH_LEN = DASH_UNITS * UNIT_CYCLES;
  localparam int CGAP_LEN = CHAR_GAP_UNITS * UNIT_CYCLES;
  localparam int MAX_A    = (DASH_LEN > CGAP_LEN) ? DASH_LEN : CGAP_LEN;
  localparam int MAX_LEN  = (MAX_A > DOT_LEN) ? MAX_A : DOT_LEN;
  localparam int CW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2,
    CGAP = 2'd3
  } state_t;

  // Returns {valid, digit} for an active-low segment pattern.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    case (seg)
      8'hC0:   seg_decode = 5'b1_0000;
      8'hF9:   seg_decode = 5'b1_0001;
      8'hA4:   seg_decode = 5'b1_0010;
      8'hB0:   seg_decode = 5'b1_0011;
      8'h99:   seg_decode = 5'b1_0100;
      8'h92:   seg_decode = 5'b1_0101;
      8'h82:   seg_decode = 5'b1_0110;
      8'hF8:   seg_decode = 5'b1_0111;
      8'h80:   seg_decode = 5'b1_1000;
      8'h90:   seg_decode = 5'b1_1001;
      default: seg_decode = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [4:0] digit_code(input logic [3:0] d);
    case (d)
      4'd1:    digit_code = 5'b01111;
      4'd2:    digit_code = 5'b00111;
      4'd3:    digit_code = 5'b00011;
      4'd4:    digit_code = 5'b00001;
      4'd6:    digit_code = 5'b10000;
      4'd7:    digit_code = 5'b11000;
      4'd8:    digit_code = 5'b11100;
      4'd9:    digit_code = 5'b11110;
      4'd0:    digit_code = 5'b11111;
      default: digit_code = 5'b00000;
    endcase
  endfunction

  function automatic logic [CW-1:0] mark_load(input logic is_dash);
    if (is_dash) begin
      mark_load = CW'(DASH_LEN - 1);
    end else begin
      mark_load = CW'(DOT_LEN - 1);
    end
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    elem_q, elem_d;
  logic [4:0]    shift_q, shift_d;
  logic [4:0]    code_q, code_d;
  logic          key_q, key_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [7:0]    seg_norm;
  logic          sel_ok;
  logic [3:0]    sel_digit;
  logic          hs;

  assign seg_norm = SEG_ACTIVE_LOW ? in_seg : ~in_seg;
  assign in_ready = (state_q == IDLE) && !abort && !rst;
  assign hs       = in_valid && in_ready;

  // Input selection and validity of the offered digit.
  always_comb begin
    sel_ok    = 1'b0;
    sel_digit = 4'd0;
    if (in_sel) begin
      sel_ok    = (in_bcd <= 4'd9);
      sel_digit = in_bcd;
    end else begin
      {sel_ok, sel_digit} = seg_decode(seg_norm);
    end
  end

  // Next-state, timing and pulse logic; shift_q[4] is the element currently on air.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    elem_d  = elem_q;
    shift_d = shift_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs && sel_ok) begin
          code_d  = digit_code(sel_digit);
          shift_d = digit_code(sel_digit);
          elem_d  = 3'd0;
          cnt_d   = mark_load(code_d[4]);
          state_d = MARK;
        end else if (hs) begin
          err_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      MARK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (elem_q == 3'd4) begin
          cnt_d   = CW'(CGAP_LEN - 1);
          state_d = CGAP;
        end else begin
          cnt_d   = CW'(DOT_LEN - 1);
          elem_d  = elem_q + 3'd1;
          shift_d = {shift_q[3:0], 1'b0};
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d   = mark_load(shift_q[4]);
          state_d = MARK;
        end
      end
      CGAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Abort cuts a character short; the code register keeps the last digit.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      state_d = state_d;
    end

    key_d  = (state_d == MARK);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      elem_q  <= 3'd0;
      shift_q <= 5'd0;
      code_q  <= 5'd0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      elem_q  <= elem_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign key_out  = key_q;
  assign busy     = busy_q;
  assign code_out = code_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_morse_digit_tx.sv
// Randomized and directed bench for morse_digit_tx against a per-cycle timeline model.
module tb_morse_digit_tx;

  localparam int U = 4;
  localparam int D = 3;
  localparam int C = 3;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_sel, abort;
  logic [7:0] in_seg;
  logic [3:0] in_bcd;
  logic       in_ready, key_out, busy, done, err;
  logic [4:0] code_out;

  morse_digit_tx #(.UNIT_CYCLES(U), .DASH_UNITS(D), .CHAR_GAP_UNITS(C), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_seg(in_seg), .in_bcd(in_bcd), .abort(abort), .key_out(key_out), .busy(busy),
    .code_out(code_out), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: remaining key levels of the character in flight, one entry per cycle.
  bit         mq[$];
  logic       m_busy, m_key, m_done, m_err;
  logic [4:0] m_code;
  int         m_accepts, acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Digit n (0 counts as 10): up to five dots lead, beyond five the dashes lead.
  function automatic logic [4:0] ref_code(input int d);
    int n;
    logic [4:0] c;
    n = (d == 0) ? 10 : d;
    for (int k = 0; k < 5; k++) begin
      if (n <= 5) c[4-k] = (k >= n);
      else        c[4-k] = (k < n - 5);
    end
    return c;
  endfunction

  function automatic bit ref_decode(input logic sel, input logic [7:0] seg, input logic [3:0] bcd,
                                    output int d);
    bit ok;
    ok = 1'b0;
    d  = 0;
    if (sel) begin
      ok = (bcd < 4'd10);
      d  = int'(bcd);
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (seg_tab[i] == seg) begin
          ok = 1'b1;
          d  = i;
        end
      end
    end
    return ok;
  endfunction

  task automatic build(input logic [4:0] code);
    for (int k = 0; k < 5; k++) begin
      repeat (code[4-k] ? D * U : U) mq.push_back(1'b1);
      if (k < 4) repeat (U) mq.push_back(1'b0);
    end
    repeat (C * U) mq.push_back(1'b0);
  endtask

  task automatic model_update();
    int d;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_key = 1'b0; m_code = 5'd0;
    end else if (m_busy) begin
      if (abort) begin
        mq.delete();
        m_busy = 1'b0; m_key = 1'b0;
      end else if (mq.size() == 0) begin
        m_busy = 1'b0; m_key = 1'b0; m_done = 1'b1;
      end else begin
        m_key = mq.pop_front();
      end
    end else if (in_valid && !abort) begin
      if (ref_decode(in_sel, in_seg, in_bcd, d)) begin
        m_code = ref_code(d);
        build(m_code);
        m_key = mq.pop_front();
        m_busy = 1'b1;
        m_accepts++;
        acc_cyc = cyc;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // One clock: check in_ready ahead of the edge, advance the model, check outputs after it.
  task automatic step();
    logic rdy_exp;
    #1;
    rdy_exp = !rst && !m_busy && !abort;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    chk("key_out", {31'd0, key_out}, {31'd0, m_key});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("code_out", {27'd0, code_out}, {27'd0, m_code});
  endtask

  // Offer one digit, then run until done; reports latency from handshake and key-high cycles.
  task automatic send(input logic sel, input logic [7:0] seg, input logic [3:0] bcd, input bit hold,
                      output int lat, output int keyhi);
    bit seen;
    seen = 1'b0;
    in_sel = sel; in_seg = seg; in_bcd = bcd; in_valid = 1'b1;
    step();
    keyhi = key_out ? 1 : 0;
    if (!hold) in_valid = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (key_out) keyhi++;
      if (done) begin
        seen = 1'b1;
        in_valid = 1'b0;
      end
    end
    lat = cyc - acc_cyc;
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int lat, keyhi, acc0;
    m_busy = 1'b0; m_key = 1'b0; m_done = 1'b0; m_err = 1'b0; m_code = 5'd0;
    m_accepts = 0; acc_cyc = 0;
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_seg = 8'hF9; in_bcd = 4'd0; abort = 1'b0;

    chk("pin_code1", {27'd0, ref_code(1)}, {27'd0, 5'b01111});
    chk("pin_code5", {27'd0, ref_code(5)}, {27'd0, 5'b00000});
    chk("pin_code7", {27'd0, ref_code(7)}, {27'd0, 5'b11000});
    chk("pin_code0", {27'd0, ref_code(0)}, {27'd0, 5'b11111});

    step(); step();
    chk("rst_code", {27'd0, code_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    send(1'b0, 8'hF9, 4'd0, 1'b0, lat, keyhi);
    chk("f9_latency", lat, 32'd81);
    chk("f9_keyhi", keyhi, 32'd52);
    chk("f9_code", {27'd0, code_out}, {27'd0, 5'b01111});

    acc0 = m_accepts;
    send(1'b1, 8'h00, 4'd0, 1'b1, lat, keyhi);
    chk("bcd0_latency", lat, 32'd89);
    chk("bcd0_keyhi", keyhi, 32'd60);
    chk("bcd0_single_accept", m_accepts - acc0, 32'd1);

    in_valid = 1'b1; in_sel = 1'b0; in_seg = 8'hFF;
    step();
    chk("err_ff", {31'd0, err}, 32'd1);
    in_sel = 1'b1; in_bcd = 4'd12;
    step();
    chk("err_bcd12", {31'd0, err}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    step();

    in_valid = 1'b1; in_sel = 1'b0; in_seg = 8'h92;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    abort = 1'b1;
    step();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_code", {27'd0, code_out}, {27'd0, 5'b00000});
    abort = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_bcd = 4'd3;
    step();
    chk("abort_reaccept", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    repeat (120) step();

    acc0 = m_accepts;
    in_valid = 1'b1; in_sel = 1'b1; in_bcd = 4'd9;
    repeat (6) step();
    chk("held_valid_once", m_accepts - acc0, 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("rst_mid_key", {31'd0, key_out}, 32'd0);
    chk("rst_mid_code", {27'd0, code_out}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 255) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = $urandom_range(0, 1) != 0;
      in_seg   = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 9)] : 8'($urandom);
      in_bcd   = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
